// File: rtl/button_repeat_conditioner.sv
// Push-button front end: two-flop synchronizer, debouncer and press/auto-repeat pulse generator.
// Emits one registered strobe per press, then repeat strobes while the button stays held.
module button_repeat_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 20_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic button,
  output logic pulse,
  output logic level,
  output logic held
);

  localparam int unsigned MaxA      = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : HOLD_CYCLES;
  localparam int unsigned MaxCycles = (MaxA > REPEAT_CYCLES) ? MaxA : REPEAT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles);

  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StRepeat
  } state_t;

  logic            s1_q, s2_q;
  logic [CntW-1:0] dcnt_q, dcnt_d;
  logic            level_q, level_d;
  logic            rise, fall;

  state_t          state_q, state_d;
  logic [CntW-1:0] rcnt_q, rcnt_d;
  logic            pulse_q, pulse_d;
  logic            held_q, held_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= button;
      s2_q <= s1_q;
    end
  end

  // Any sample agreeing with the current level restarts the count.
  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    if (s2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DebLast) begin
      dcnt_d  = '0;
      level_d = ~level_q;
    end else begin
      dcnt_d = dcnt_q + CntW'(1);
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dcnt_q  <= '0;
      level_q <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
    end
  end

  // Release wins over a coincident hold/repeat terminal count.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    pulse_d = 1'b0;
    held_d  = held_q;
    if (fall) begin
      state_d = StIdle;
      rcnt_d  = '0;
      held_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          rcnt_d = '0;
          held_d = 1'b0;
          if (rise) begin
            pulse_d = 1'b1;
            state_d = StPress;
          end
        end
        StPress: begin
          if (rcnt_q == HoldLast) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
            held_d  = 1'b1;
            state_d = StRepeat;
          end else begin
            rcnt_d = rcnt_q + CntW'(1);
          end
        end
        StRepeat: begin
          if (rcnt_q == RepLast) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          rcnt_d  = '0;
          held_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      rcnt_q  <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;
  assign held  = held_q;

endmodule

// File: tb/tb_button_repeat_conditioner.sv
// Scoreboard bench: stimulus queues expected pulse cycles, a negedge monitor pops and compares.
module tb_button_repeat_conditioner;

  logic clk;
  logic clr;
  logic button;
  logic pulse;
  logic level;
  logic held;

  int unsigned cyc;
  int          checks;
  int          failures;
  int unsigned exp_q[$];

  button_repeat_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .button(button),
    .pulse (pulse),
    .level (level),
    .held  (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    checks   = 0;
    failures = 0;
  end

  // Each observed pulse must match the next expected cycle number.
  always @(negedge clk) begin
    if (pulse) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL pulse_unexpected at cycle %0d: got pulse=1 want no pulse", cyc);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          failures = failures + 1;
          $display("FAIL pulse_time: got pulse at cycle %0d want cycle %0d", cyc, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic wait_until(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  int unsigned k;
  int unsigned k2;

  initial begin
    clr    = 1'b1;
    button = 1'b1;

    // Reset held with button high: everything stays low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_level", level, 1'b0);
      chk("rst_pulse", pulse, 1'b0);
      chk("rst_held", held, 1'b0);
    end
    k   = cyc;
    clr = 1'b0;
    exp_q.push_back(k + 6);
    wait_until(k + 5);
    chk("rst_level_before", level, 1'b0);
    wait_until(k + 6);
    chk("rst_level_rise", level, 1'b1);
    wait_until(k + 8);
    button = 1'b0;
    wait_until(k + 14);
    chk("rst_level_fall", level, 1'b0);
    repeat (5) @(negedge clk);

    // Clean short press.
    k      = cyc;
    button = 1'b1;
    exp_q.push_back(k + 6);
    wait_until(k + 8);
    button = 1'b0;
    wait_until(k + 13);
    chk("short_level_high", level, 1'b1);
    chk("short_held", held, 1'b0);
    wait_until(k + 14);
    chk("short_level_fall", level, 1'b0);
    repeat (5) @(negedge clk);

    // Bounce rejection.
    for (int i = 0; i < 5; i++) begin
      button = 1'b1;
      repeat (2) @(negedge clk);
      button = 1'b0;
      @(negedge clk);
      chk("bounce_level", level, 1'b0);
    end
    repeat (10) @(negedge clk);
    chk("bounce_level_end", level, 1'b0);

    // Hold and repeat.
    k      = cyc;
    button = 1'b1;
    exp_q.push_back(k + 6);
    exp_q.push_back(k + 16);
    exp_q.push_back(k + 19);
    exp_q.push_back(k + 22);
    exp_q.push_back(k + 25);
    exp_q.push_back(k + 28);
    exp_q.push_back(k + 31);
    exp_q.push_back(k + 34);
    wait_until(k + 15);
    chk("hold_held_pre", held, 1'b0);
    wait_until(k + 16);
    chk("hold_held_rise", held, 1'b1);
    wait_until(k + 30);
    button = 1'b0;
    wait_until(k + 35);
    chk("hold_held_late", held, 1'b1);
    chk("hold_level_late", level, 1'b1);
    wait_until(k + 36);
    chk("hold_held_fall", held, 1'b0);
    chk("hold_level_fall", level, 1'b0);
    repeat (10) @(negedge clk);

    // Release coinciding with hold terminal count.
    k      = cyc;
    button = 1'b1;
    exp_q.push_back(k + 6);
    wait_until(k + 10);
    button = 1'b0;
    wait_until(k + 15);
    chk("tc_level_pre", level, 1'b1);
    wait_until(k + 16);
    chk("tc_level_fall", level, 1'b0);
    chk("tc_held", held, 1'b0);
    wait_until(k + 17);
    chk("tc_held_after", held, 1'b0);
    repeat (10) @(negedge clk);

    // Async reset mid-repeat, then resume as a fresh press.
    k      = cyc;
    button = 1'b1;
    exp_q.push_back(k + 6);
    exp_q.push_back(k + 16);
    exp_q.push_back(k + 19);
    wait_until(k + 20);
    chk("arst_held_pre", held, 1'b1);
    #2 clr = 1'b1;
    #1;
    chk("arst_held", held, 1'b0);
    chk("arst_level", level, 1'b0);
    chk("arst_pulse", pulse, 1'b0);
    @(negedge clk);
    k2  = cyc;
    clr = 1'b0;
    exp_q.push_back(k2 + 6);
    wait_until(k2 + 5);
    chk("arst_level_before", level, 1'b0);
    wait_until(k2 + 6);
    chk("arst_level_rise", level, 1'b1);
    wait_until(k2 + 8);
    button = 1'b0;
    wait_until(k2 + 14);
    chk("arst_level_fall", level, 1'b0);

    repeat (20) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL pulse_missing: got %0d pulses outstanding want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
